csr_file_m: RTL and testbench

- Parametrised successor to the machine-mode CSR register file.
- Adds read/modify/write CSR ops (write/set/clear), hardware trap entry and mret, synchronised interrupt-pending logic with vectored mtvec, illegal-access detection, and optional 64-bit cycle/instret counters.
- Sits in the execute stage beside the ALU; feeds trap target and mepc to the PC-select logic.

---
 rtl/csr_file_m_if.sv | 13 +
 rtl/csr_file_m.sv | 162 ++++++++++++++++
 tb/tb_csr_file_m.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_file_m_if.sv
// csr_file_m_if: CSR access bus between the execute stage and csr_file_m.
interface csr_file_m_if #(
    parameter int DW    = 32,
    parameter int ADDRW = 12
);
    logic [ADDRW-1:0] csr_addr_i;
    logic [1:0]       csr_op_i;
    logic [DW-1:0]    csr_wdata_i;
    logic [DW-1:0]    csr_rdata_o;
    logic             csr_illegal_o;
    modport master (output csr_addr_i, csr_op_i, csr_wdata_i, input csr_rdata_o, csr_illegal_o);
    modport slave  (input csr_addr_i, csr_op_i, csr_wdata_i, output csr_rdata_o, csr_illegal_o);
endinterface

// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR file with RMW ops, trap/mret, synchronised irqs and vectored mtvec.
// Define CSR_COUNTERS_EN to build the mcycle/minstret counters.
module csr_file_m #(
    parameter int              DW        = 32,
    parameter int              ADDRW     = 12,
    parameter logic [DW-1:0]   MTVEC_RST = '0,
    parameter int              CNT_W     = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    csr_file_m_if.slave   bus,
    input  logic          trap_i,
    input  logic [DW-1:0] trap_cause_i,
    input  logic [DW-1:0] trap_pc_i,
    input  logic          mret_i,
    input  logic          instr_ret_i,
    input  logic          irq_ext_i,
    input  logic          irq_tmr_i,
    input  logic          irq_sw_i,
    output logic          irq_pending_o,
    output logic [DW-1:0] irq_cause_o,
    output logic [DW-1:0] trap_vec_o,
    output logic [DW-1:0] mepc_o
);
    localparam logic [ADDRW-1:0] A_MSTATUS  = ADDRW'(12'h300);
    localparam logic [ADDRW-1:0] A_MIE      = ADDRW'(12'h304);
    localparam logic [ADDRW-1:0] A_MTVEC    = ADDRW'(12'h305);
    localparam logic [ADDRW-1:0] A_MSCRATCH = ADDRW'(12'h340);
    localparam logic [ADDRW-1:0] A_MEPC     = ADDRW'(12'h341);
    localparam logic [ADDRW-1:0] A_MCAUSE   = ADDRW'(12'h342);
    localparam logic [ADDRW-1:0] A_MIP      = ADDRW'(12'h344);
    localparam logic [DW-1:0]    MIE_MASK   = DW'(32'h0000_0888);
    localparam logic [DW-1:0]    CAUSE_MEI  = {1'b1, (DW-1)'(11)};
    localparam logic [DW-1:0]    CAUSE_MSI  = {1'b1, (DW-1)'(3)};
    localparam logic [DW-1:0]    CAUSE_MTI  = {1'b1, (DW-1)'(7)};

    if (CNT_W > 2*DW) begin : g_bad_cnt_w
        $error("CNT_W must not exceed 2*DW");
    end

    logic          mie_b, mpie_b;
    logic [DW-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [2:0]    irq_s1, irq_s2;
    logic [DW-1:0] mstatus_w, mip_w, pend_w, rdata, wval;
    logic          mapped, illegal, wr_en;

`ifdef CSR_COUNTERS_EN
    localparam logic [ADDRW-1:0] A_MCYCLE    = ADDRW'(12'hB00);
    localparam logic [ADDRW-1:0] A_MINSTRET  = ADDRW'(12'hB02);
    localparam logic [ADDRW-1:0] A_MCYCLEH   = ADDRW'(12'hB80);
    localparam logic [ADDRW-1:0] A_MINSTRETH = ADDRW'(12'hB82);
    logic [CNT_W-1:0] mcycle_q, minstret_q;
    logic [2*DW-1:0]  cyc_x, ins_x;
    assign cyc_x = (2*DW)'(mcycle_q);
    assign ins_x = (2*DW)'(minstret_q);
`else
    logic unused_instr_ret;
    assign unused_instr_ret = instr_ret_i;
`endif

    always_comb begin
        mstatus_w        = '0;
        mstatus_w[12:11] = 2'b11;
        mstatus_w[7]     = mpie_b;
        mstatus_w[3]     = mie_b;
        mip_w            = '0;
        mip_w[11]        = irq_s2[2];
        mip_w[7]         = irq_s2[1];
        mip_w[3]         = irq_s2[0];
        rdata            = '0;
        mapped           = 1'b1;
        case (bus.csr_addr_i)
            A_MSTATUS:   rdata = mstatus_w;
            A_MIE:       rdata = mie_q;
            A_MTVEC:     rdata = mtvec_q;
            A_MSCRATCH:  rdata = mscratch_q;
            A_MEPC:      rdata = mepc_q;
            A_MCAUSE:    rdata = mcause_q;
            A_MIP:       rdata = mip_w;
`ifdef CSR_COUNTERS_EN
            A_MCYCLE:    rdata = cyc_x[DW-1:0];
            A_MCYCLEH:   rdata = cyc_x[2*DW-1:DW];
            A_MINSTRET:  rdata = ins_x[DW-1:0];
            A_MINSTRETH: rdata = ins_x[2*DW-1:DW];
`endif
            default:     mapped = 1'b0;
        endcase
    end

    assign wval    = bus.csr_op_i == 2'b01 ? bus.csr_wdata_i :
                     bus.csr_op_i == 2'b10 ? rdata | bus.csr_wdata_i : rdata & ~bus.csr_wdata_i;
    assign illegal = |bus.csr_op_i &&
                     (!mapped || (bus.csr_addr_i == A_MIP && (bus.csr_op_i == 2'b01 || |bus.csr_wdata_i)));
    // set/clear with a zero operand is a pure read and must not write
    assign wr_en   = |bus.csr_op_i && !illegal && !(bus.csr_op_i[1] && ~|bus.csr_wdata_i) && !trap_i && !mret_i;

    assign bus.csr_rdata_o   = rdata;
    assign bus.csr_illegal_o = illegal;
    assign mepc_o            = mepc_q;

    assign pend_w        = mip_w & mie_q;
    assign irq_pending_o = mie_b & |pend_w;
    assign irq_cause_o   = pend_w[11] ? CAUSE_MEI : pend_w[3] ? CAUSE_MSI : pend_w[7] ? CAUSE_MTI : '0;
    assign trap_vec_o    = {mtvec_q[DW-1:2], 2'b00} +
                           ((mtvec_q[0] && trap_cause_i[DW-1]) ? DW'({trap_cause_i[DW-2:0], 2'b00}) : '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mie_b      <= 1'b0;
            mpie_b     <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= {MTVEC_RST[DW-1:2], 1'b0, MTVEC_RST[0]};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            irq_s1     <= '0;
            irq_s2     <= '0;
        end else begin
            irq_s1 <= {irq_ext_i, irq_tmr_i, irq_sw_i};
            irq_s2 <= irq_s1;
            if (trap_i) begin
                mepc_q   <= {trap_pc_i[DW-1:2], 2'b00};
                mcause_q <= trap_cause_i;
                mpie_b   <= mie_b;
                mie_b    <= 1'b0;
            end else if (mret_i) begin
                mie_b  <= mpie_b;
                mpie_b <= 1'b1;
            end else if (wr_en) begin
                case (bus.csr_addr_i)
                    A_MSTATUS: begin
                        mie_b  <= wval[3];
                        mpie_b <= wval[7];
                    end
                    A_MIE:      mie_q      <= wval & MIE_MASK;
                    A_MTVEC:    mtvec_q    <= {wval[DW-1:2], 1'b0, wval[0]};
                    A_MSCRATCH: mscratch_q <= wval;
                    A_MEPC:     mepc_q     <= {wval[DW-1:2], 2'b00};
                    A_MCAUSE:   mcause_q   <= wval;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    // a write to either half replaces that cycle's increment of the whole counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= (wr_en && bus.csr_addr_i == A_MCYCLE)    ? CNT_W'({cyc_x[2*DW-1:DW], wval}) :
                          (wr_en && bus.csr_addr_i == A_MCYCLEH)   ? CNT_W'({wval, cyc_x[DW-1:0]}) :
                          mcycle_q + CNT_W'(1);
            minstret_q <= (wr_en && bus.csr_addr_i == A_MINSTRET)  ? CNT_W'({ins_x[2*DW-1:DW], wval}) :
                          (wr_en && bus.csr_addr_i == A_MINSTRETH) ? CNT_W'({wval, ins_x[DW-1:0]}) :
                          minstret_q + CNT_W'(instr_ret_i);
        end
    end
`endif
endmodule

// File: tb/tb_csr_file_m.sv
// tb_csr_file_m: vector table, directed trap/irq/counter sequences and random run against a reference model.
module tb_csr_file_m;
    logic        clk = 1'b0, rst = 1'b1;
    logic        trap_i = 1'b0, mret_i = 1'b0, instr_ret = 1'b0;
    logic        irq_ext = 1'b0, irq_tmr = 1'b0, irq_sw = 1'b0;
    logic [31:0] trap_cause = '0, trap_pc = '0;
    logic        irq_pending;
    logic [31:0] irq_cause, trap_vec, mepc;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    csr_file_m_if #(.DW(32), .ADDRW(12)) bus ();

    csr_file_m dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .trap_i(trap_i), .trap_cause_i(trap_cause), .trap_pc_i(trap_pc),
        .mret_i(mret_i), .instr_ret_i(instr_ret),
        .irq_ext_i(irq_ext), .irq_tmr_i(irq_tmr), .irq_sw_i(irq_sw),
        .irq_pending_o(irq_pending), .irq_cause_o(irq_cause),
        .trap_vec_o(trap_vec), .mepc_o(mepc)
    );

    bit              m_mie, m_mpie;
    bit [31:0]       m_mier, m_mtvec, m_scr, m_mepc, m_mcause;
    bit [2:0]        irq_q[$];
    longint unsigned m_cyc, m_ins;

    function automatic void m_reset();
        m_mie = 0; m_mpie = 0; m_mier = 0; m_mtvec = 0; m_scr = 0; m_mepc = 0; m_mcause = 0;
        irq_q = '{3'b000, 3'b000};
        m_cyc = 0; m_ins = 0;
    endfunction

    function automatic bit m_mapped(bit [11:0] a);
        case (a)
            12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344: return 1'b1;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [31:0] m_mip();
        return {20'b0, irq_q[0][2], 3'b0, irq_q[0][1], 3'b0, irq_q[0][0], 3'b0};
    endfunction

    function automatic bit [31:0] m_read(bit [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304: return m_mier;
            12'h305: return m_mtvec;
            12'h340: return m_scr;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip();
`ifdef CSR_COUNTERS_EN
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_illegal(bit [11:0] a, bit [1:0] op, bit [31:0] wd);
        return op != 0 && (!m_mapped(a) || (a == 12'h344 && (op == 1 || wd != 0)));
    endfunction

    function automatic bit [31:0] m_vec(bit [31:0] c);
        bit [31:0] v = m_mtvec & ~32'h3;
        if (m_mtvec[0] && c[31]) v = v + {1'b0, c[30:0]} * 32'd4;
        return v;
    endfunction

    function automatic bit [31:0] m_cause();
        bit [31:0] p = m_mip() & m_mier;
        return p[11] ? 32'h8000_000B : p[3] ? 32'h8000_0003 : p[7] ? 32'h8000_0007 : 32'h0;
    endfunction

    // advance the model by one clock edge using the inputs currently applied
    function automatic void m_step();
        bit [11:0]       a = bus.csr_addr_i;
        bit [1:0]        op = bus.csr_op_i;
        bit [31:0]       wd = bus.csr_wdata_i, old, nv;
        longint unsigned oc = m_cyc, oi = m_ins;
        bit              wr;
        if (rst) begin
            m_reset();
            return;
        end
        old = m_read(a);
        nv  = op == 1 ? wd : op == 2 ? (old | wd) : (old & ~wd);
        wr  = !trap_i && !mret_i && op != 0 && !m_illegal(a, op, wd) && !(op >= 2 && wd == 0);
        m_cyc = m_cyc + 1;
        if (instr_ret) m_ins = m_ins + 1;
        if (trap_i) begin
            m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mpie = m_mie; m_mie = 0;
        end else if (mret_i) begin
            m_mie = m_mpie; m_mpie = 1;
        end else if (wr) begin
            case (a)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_mier = nv & 32'h888;
                12'h305: m_mtvec = nv & ~32'h2;
                12'h340: m_scr = nv;
                12'h341: m_mepc = nv & ~32'h3;
                12'h342: m_mcause = nv;
                12'hB00: m_cyc = {oc[63:32], nv};
                12'hB80: m_cyc = {nv, oc[31:0]};
                12'hB02: m_ins = {oi[63:32], nv};
                12'hB82: m_ins = {nv, oi[31:0]};
                default: ;
            endcase
        end
        irq_q.push_back({irq_ext, irq_tmr, irq_sw});
        void'(irq_q.pop_front());
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", n, act, exp);
        else passed++;
    endtask

    task automatic drv(bit [11:0] a, bit [1:0] op, bit [31:0] wd);
        bus.csr_addr_i = a; bus.csr_op_i = op; bus.csr_wdata_i = wd;
    endtask

    task automatic tick();
        #1;
        chk("model_rdata", bus.csr_rdata_o, m_read(bus.csr_addr_i));
        chk("model_illegal", 32'(bus.csr_illegal_o), 32'(m_illegal(bus.csr_addr_i, bus.csr_op_i, bus.csr_wdata_i)));
        chk("model_trap_vec", trap_vec, m_vec(trap_cause));
        chk("model_mepc", mepc, m_mepc);
        chk("model_irq_pending", 32'(irq_pending), 32'(m_mie && (m_mip() & m_mier) != 0));
        if (m_mie) chk("model_irq_cause", irq_cause, m_cause());
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    typedef struct {
        bit [11:0] a;
        bit [1:0]  op;
        bit [31:0] wd;
        bit [31:0] rd;
        bit        ill;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t      tbl[$];
        bit [11:0] addrs[13] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                                 12'h7C0, 12'h301, 12'hB00, 12'hB80, 12'hB02, 12'hB82};
        tbl.push_back('{12'h300, 2'd0, 32'h0,         32'h0000_1800, 1'b0});
        tbl.push_back('{12'h305, 2'd0, 32'h0,         32'h0000_0000, 1'b0});
        tbl.push_back('{12'h304, 2'd1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
        tbl.push_back('{12'h304, 2'd0, 32'h0,         32'h0000_0888, 1'b0});
        tbl.push_back('{12'h300, 2'd2, 32'h8,         32'h0000_1800, 1'b0});
        tbl.push_back('{12'h300, 2'd0, 32'h0,         32'h0000_1808, 1'b0});
        tbl.push_back('{12'h300, 2'd3, 32'h8,         32'h0000_1808, 1'b0});
        tbl.push_back('{12'h300, 2'd0, 32'h0,         32'h0000_1800, 1'b0});
        tbl.push_back('{12'h344, 2'd1, 32'h1,         32'h0000_0000, 1'b1});
        tbl.push_back('{12'h7C0, 2'd2, 32'h5,         32'h0000_0000, 1'b1});
        tbl.push_back('{12'h7C0, 2'd0, 32'h0,         32'h0000_0000, 1'b0});
        tbl.push_back('{12'h344, 2'd2, 32'h0,         32'h0000_0000, 1'b0});
        tbl.push_back('{12'h340, 2'd1, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
        tbl.push_back('{12'h340, 2'd3, 32'h0,         32'hDEAD_BEEF, 1'b0});
        tbl.push_back('{12'h340, 2'd0, 32'h0,         32'hDEAD_BEEF, 1'b0});
        tbl.push_back('{12'h305, 2'd1, 32'h0000_1003, 32'h0000_0000, 1'b0});
        tbl.push_back('{12'h305, 2'd0, 32'h0,         32'h0000_1001, 1'b0});
        tbl.push_back('{12'h341, 2'd1, 32'h0000_0107, 32'h0000_0000, 1'b0});
        tbl.push_back('{12'h341, 2'd0, 32'h0,         32'h0000_0104, 1'b0});

        drv(12'h300, 2'd0, 32'h0);
        repeat (2) @(posedge clk);
        m_reset();
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drv(tbl[i].a, tbl[i].op, tbl[i].wd);
            #1;
            chk($sformatf("tbl%0d_rdata", i), bus.csr_rdata_o, tbl[i].rd);
            chk($sformatf("tbl%0d_illegal", i), 32'(bus.csr_illegal_o), 32'(tbl[i].ill));
            tick();
        end

        // external interrupt: 2-cycle synchroniser latency, then a vectored trap
        drv(12'h300, 2'd2, 32'h8);
        tick();
        drv(12'h300, 2'd0, 32'h0);
        irq_ext = 1'b1;
        tick();
        chk("irq_after_1", 32'(irq_pending), 32'h0);
        tick();
        chk("irq_after_2", 32'(irq_pending), 32'h1);
        chk("irq_cause_mei", irq_cause, 32'h8000_000B);
        trap_i = 1'b1; trap_cause = 32'h8000_000B; trap_pc = 32'h0000_0106;
        #1 chk("trap_vec_vectored", trap_vec, 32'h0000_102C);
        tick();
        trap_i = 1'b0;
        #1 chk("trap_mepc", mepc, 32'h0000_0104);
        chk("trap_mstatus", bus.csr_rdata_o, 32'h0000_1880);
        chk("trap_masks_irq", 32'(irq_pending), 32'h0);
        drv(12'h342, 2'd0, 32'h0);
        #1 chk("trap_mcause", bus.csr_rdata_o, 32'h8000_000B);

        // trap beats a same-cycle CSR write; mret beats one too
        irq_ext = 1'b0;
        drv(12'h300, 2'd2, 32'h8);
        tick();
        trap_i = 1'b1; trap_cause = 32'h0000_0007; trap_pc = 32'h0000_0200;
        drv(12'h342, 2'd1, 32'h5);
        tick();
        trap_i = 1'b0;
        drv(12'h342, 2'd0, 32'h0);
        #1 chk("trap_drops_write", bus.csr_rdata_o, 32'h0000_0007);
        mret_i = 1'b1;
        drv(12'h340, 2'd1, 32'h0);
        #1 chk("mret_still_reads", bus.csr_rdata_o, 32'hDEAD_BEEF);
        tick();
        mret_i = 1'b0;
        drv(12'h300, 2'd0, 32'h0);
        #1 chk("mret_mstatus", bus.csr_rdata_o, 32'h0000_1888);
        drv(12'h340, 2'd0, 32'h0);
        #1 chk("mret_drops_write", bus.csr_rdata_o, 32'hDEAD_BEEF);

`ifdef CSR_COUNTERS_EN
        drv(12'hB00, 2'd1, 32'hFFFF_FFFF);
        tick();
        drv(12'hB80, 2'd1, 32'h0);
        tick();
        drv(12'hB00, 2'd0, 32'h0);
        tick();
        chk("mcycle_wrap_lo", bus.csr_rdata_o, 32'h0);
        drv(12'hB80, 2'd0, 32'h0);
        #1 chk("mcycle_wrap_hi", bus.csr_rdata_o, 32'h1);
        instr_ret = 1'b1;
        repeat (3) tick();
        instr_ret = 1'b0;
        drv(12'hB02, 2'd0, 32'h0);
        #1 chk("minstret_3", bus.csr_rdata_o, 32'h3);
`else
        drv(12'hB00, 2'd1, 32'h1);
        #1 chk("mcycle_unmapped", 32'(bus.csr_illegal_o), 32'h1);
        drv(12'hB82, 2'd2, 32'h0);
        #1 chk("minstreth_unmapped", 32'(bus.csr_illegal_o), 32'h1);
        tick();
`endif

        // reset beats a same-cycle trap and write
        rst = 1'b1; trap_i = 1'b1; trap_cause = 32'h5; trap_pc = 32'h300;
        drv(12'h340, 2'd1, 32'h1234);
        tick();
        rst = 1'b0; trap_i = 1'b0;
        drv(12'h340, 2'd0, 32'h0);
        #1 chk("rst_mscratch", bus.csr_rdata_o, 32'h0);
        chk("rst_mepc", mepc, 32'h0);
        drv(12'h300, 2'd0, 32'h0);
        #1 chk("rst_mstatus", bus.csr_rdata_o, 32'h0000_1800);
        drv(12'h305, 2'd0, 32'h0);
        #1 chk("rst_mtvec", bus.csr_rdata_o, 32'h0);

        repeat (600) begin
            drv(addrs[$urandom_range(0, 12)], 2'($urandom_range(0, 3)),
                $urandom_range(0, 3) == 0 ? 32'h0 : $urandom_range(0, 1) ? 32'h888 : $urandom);
            trap_i     = $urandom_range(0, 15) == 0;
            mret_i     = $urandom_range(0, 15) == 0;
            rst        = $urandom_range(0, 99) == 0;
            instr_ret  = 1'($urandom_range(0, 1));
            trap_cause = $urandom_range(0, 1) ? (32'h8000_0000 | $urandom_range(0, 15)) : $urandom;
            trap_pc    = $urandom;
            if ($urandom_range(0, 7) == 0) irq_ext = ~irq_ext;
            if ($urandom_range(0, 7) == 0) irq_tmr = ~irq_tmr;
            if ($urandom_range(0, 7) == 0) irq_sw  = ~irq_sw;
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
